mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit for the pipelined core's execute stage.
- Generalises the existing fixed 32-bit multiplier (start/sign/done handshake) in three ways:
  - adds signed and unsigned divide;
  - makes the operand width configurable;
  - adds HI/LO write-back and a pipeline-flush cancel.
- The hazard unit stalls on `busy` and releases on `done`.

---
 rtl/mdu_iter.sv | 190 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers.
//   op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
//   Signed operations run on magnitudes; signs are reapplied in the FIX state.
//   Optional macro MDU_EARLY_OUT_EN: a zero operand skips CALC and jumps to FIX.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;  // product / quotient must be negated
  logic             neg_rem_q, neg_rem_d;  // remainder follows a negative dividend
  logic             dz_q, dz_d;            // divide with b == 0
  // acc: product upper half / partial remainder
  // low: multiplier shifting out, product lower half / dividend shifting out, quotient
  // opnd: multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return -x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return -x;
  endfunction

  // Operand conditioning for a new request
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             accept;

  // One iteration of each algorithm, plus the sign-fixed results
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  // Datapath arithmetic shared by the next-state logic
  always_comb begin
    a_neg     = op[0] & a[WIDTH-1];
    b_neg     = op[0] & b[WIDTH-1];
    mag_a     = a_neg ? neg_w(a) : a;
    mag_b     = b_neg ? neg_w(b) : b;
    accept    = start & ~cancel & ((state_q == S_IDLE) | (state_q == S_DONE));
    mul_sum   = {1'b0, acc_q} + {1'b0, (low_q[0] ? opnd_q : '0)};
    div_shift = {acc_q, low_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    prod_fix  = neg_res_q ? neg_2w({acc_q, low_q}) : {acc_q, low_q};
  end

  // Next-state and next-register logic for the control FSM and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (accept) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op[1] & (b == '0);
          acc_d     = '0;
          low_d     = op[1] ? mag_a : mag_b;
          opnd_d    = op[1] ? mag_b : mag_a;
`ifdef MDU_EARLY_OUT_EN
          // A zero operand has a known result: zero, or |a| as the
          // remainder of a divide by zero (quotient is forced in FIX).
          if ((a == '0) || (b == '0)) begin
            state_d = S_FIX;
            low_d   = '0;
            acc_d   = op[1] ? mag_a : '0;
          end
`endif
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = S_FIX;
          if (is_div_q) begin
            acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            low_d = {low_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            low_d = {mul_sum[0], low_q[WIDTH-1:1]};
          end
        end
      end
      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (is_div_q) begin
            hi_d = neg_rem_q ? neg_w(acc_q) : acc_q;
            if (dz_q)           lo_d = '1;
            else if (neg_res_q) lo_d = neg_w(low_q);
            else                lo_d = low_q;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architectural registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Working registers only matter between accept and FIX, so no reset
  always_ff @(posedge clk) begin
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    acc_q     <= acc_d;
    low_q     <= low_d;
    opnd_q    <= opnd_d;
  end

  assign busy    = (state_q == S_CALC) | (state_q == S_FIX);
  assign done    = (state_q == S_DONE);
  assign divzero = (state_q == S_DONE) & dz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: cycle-level reference model plus directed vectors.
module tb_mdu_iter;
  localparam int W = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         reset, start, cancel, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, divzero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one operation: {divzero, hi, lo}
  function automatic logic [2*W:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0]        up;
    logic signed [2*W-1:0] ex, ey, sp;
    logic signed [W-1:0]   sx, sy, sq, sr;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return {1'b0, up};
      end
      2'b01: begin
        ex = sx;
        ey = sy;
        sp = ex * ey;
        return {1'b0, sp};
      end
      2'b10: begin
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        return {1'b0, x % y, x / y};
      end
      default: begin
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        if (x == {1'b1, {(W-1){1'b0}}} && y == {W{1'b1}})
          return {1'b0, {W{1'b0}}, x};
        sq = sx / sy;
        sr = sx % sy;
        return {1'b0, sr, sq};
      end
    endcase
  endfunction

  function automatic bit takes_shortcut(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MDU_EARLY_OUT_EN
    return (x == '0) || (y == '0);
`else
    return 1'b0 & (x == y);
`endif
  endfunction

  // Reference model: busy for W+1 cycles (or 1 with a shortcut) then one done cycle
  logic         m_busy, m_done, m_dz;
  logic [W-1:0] m_hi, m_lo;
  int           m_rem;
  logic [2*W:0] p_res;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_busy) begin
        if (cancel) m_busy <= 1'b0;
        else if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dz   <= p_res[2*W];
          m_hi   <= p_res[2*W-1:W];
          m_lo   <= p_res[W-1:0];
        end else m_rem <= m_rem - 1;
      end else begin
        if (wr_hi) m_hi <= wdata;
        if (wr_lo) m_lo <= wdata;
        if (start && !cancel) begin
          p_res  <= ref_op(op, a, b);
          m_busy <= 1'b1;
          m_rem  <= takes_shortcut(a, b) ? 1 : W + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("divzero", {31'b0, divzero}, {31'b0, m_dz});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // Waits (from a negedge where start is set) for done; cyc = cycle of done
  task automatic wait_done(input int wr_at, output int cyc);
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      wr_hi = 1'b0;
      wr_lo = (cyc == wr_at);
      if (cyc == wr_at) wdata = 32'h12345678;
      if (done) break;
      if (cyc >= 200) begin
        total++;
        bad++;
        $display("FAIL timeout: no done after %0d cycles, required one", cyc);
        break;
      end
    end
    wr_lo = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int cyc);
    op = o; a = x; b = y; start = 1'b1;
    wait_done(-1, cyc);
  endtask

  int cyc, dcount;

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;

    // Signed multiply: -3 * 7
    run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, cyc);
    check("mult_lat", cyc, 32'd34);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);

    // Unsigned max squared; an HI write lands with the start and is overwritten
    wr_hi = 1'b1; wdata = 32'hDEADBEEF;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    // Signed divides including the overflow case
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, cyc);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, cyc);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h00000000);
    check("divovf_dz", {31'b0, divzero}, 32'd0);

    // Divide by zero, unsigned and signed
    run_op(2'b10, 32'h00000064, 32'h00000000, cyc);
    check("divu0_lat", cyc, ZLAT);
    check("divu0_lo", lo, 32'hFFFFFFFF);
    check("divu0_hi", hi, 32'h00000064);
    check("divu0_dz", {31'b0, divzero}, 32'd1);
    run_op(2'b11, 32'hFFFFFFF9, 32'h00000000, cyc);
    check("div0_lo", lo, 32'hFFFFFFFF);
    check("div0_hi", hi, 32'hFFFFFFF9);

    // Zero multiplicand
    run_op(2'b01, 32'h00000000, 32'h00000005, cyc);
    check("mul0_lat", cyc, ZLAT);
    check("mul0_hi", hi, 32'h0);
    check("mul0_lo", lo, 32'h0);

    // Idle writes to HI and LO, then a cancelled multiply
    wr_hi = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h5A5A5A5A;
    @(negedge clk);
    wr_lo = 1'b0;
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    dcount = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dcount++;
      start = (c == 5);
      if (c == 5) begin op = 2'b10; a = 32'd9; b = 32'd3; end
      cancel = (c == 10);
      if (c == 11) check("cancel_busy", {31'b0, busy}, 32'd0);
    end
    check("cancel_nodone", dcount, 32'd0);
    check("cancel_hi", hi, 32'hA5A5A5A5);
    check("cancel_lo", lo, 32'h5A5A5A5A);

    // Back-to-back: new start in the DONE cycle, busy write ignored
    run_op(2'b10, 32'd7, 32'd2, cyc);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
    op = 2'b00; a = 32'd3; b = 32'd5; start = 1'b1;
    wait_done(3, cyc);
    check("b2b_lat", cyc, 32'd34);
    check("b2b_lo", lo, 32'd15);
    check("b2b_hi", hi, 32'd0);
    wr_lo = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo_lo", lo, 32'h12345678);

    // Reset in the middle of an operation
    op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1; cancel = 1'b1;
    @(negedge clk);
    reset = 1'b0; cancel = 1'b0;
    check("rstop_busy", {31'b0, busy}, 32'd0);
    check("rstop_hi", hi, 32'd0);
    check("rstop_lo", lo, 32'd0);
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
